rc4_core_arbiter: RTL and testbench

Top-level search controller and result collector for the multi-core RC4 key brute-force. It sits directly downstream of the `rc4_encapsulated` cores, which do not know about each other. It resets and starts `NUM_CORES` cores together and watches each core's `correct_key_found` / `secret_key` pair. It latches the first winning key and core index, and reports "not found" once every core has swept its share of the 22-bit keyspace.

---
 rtl/rc4_pkg.sv | 15 +
 rtl/rc4_wrap_detect.sv | 30 +++
 rtl/rc4_core_arbiter.sv | 119 +++++++++++
 tb/tb_rc4_core_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared types and widths for the RC4 brute-force search controller.
package rc4_pkg;
  localparam int KEY_W      = 24;
  localparam int KEYSPACE_W = 22;
  localparam int MAX_CORES  = 255;

  typedef enum logic [2:0] {
    IDLE,
    RESET_CORES,
    START,
    SEARCH,
    FOUND,
    EXHAUSTED
  } arb_state_t;
endpackage

// File: rtl/rc4_wrap_detect.sv
// Per-core sweep tracker: the flag sticks once the core's key counter wraps.
module rc4_wrap_detect
  import rc4_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [KEY_W-1:0] key,
  output logic             exhausted
);
  logic [KEY_W-1:0] prev_key;
  logic             prev_vld;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_key  <= '0;
      prev_vld  <= 1'b0;
      exhausted <= 1'b0;
    end else if (clear) begin
      prev_vld  <= 1'b0;
      exhausted <= 1'b0;
    end else if (en) begin
      prev_key <= key;
      prev_vld <= 1'b1;
      // A smaller key than last cycle means the counter rolled over.
      if (prev_vld && (key < prev_key)) exhausted <= 1'b1;
    end
  end
endmodule

// File: rtl/rc4_core_arbiter.sv
// Starts all RC4 cores together, latches the first winning key, or flags exhaustion.
module rc4_core_arbiter
  import rc4_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int RST_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       go,
  input  logic [NUM_CORES-1:0]       core_found,
  input  logic [KEY_W*NUM_CORES-1:0] core_key,
  output logic                       core_reset,
  output logic                       core_start,
  output logic [7:0]                 total_cores,
  output logic                       busy,
  output logic                       found,
  output logic                       not_found,
  output logic [KEY_W-1:0]           found_key,
  output logic [7:0]                 found_core,
  output logic [31:0]                search_cycles
);
  localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  arb_state_t           state;
  logic [CNT_W-1:0]     rst_cnt;
  logic [NUM_CORES-1:0] exhausted;
  logic                 det_clear, det_en;
  logic                 any_found;
  logic [7:0]           win_idx;
  logic [KEY_W-1:0]     win_key;

  assign total_cores = 8'(NUM_CORES);
  assign det_en      = (state == SEARCH);
  assign det_clear   = (state == RESET_CORES) || (state == START);

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_wrap
    rc4_wrap_detect u_wd (
      .clk      (clk),
      .reset    (reset),
      .clear    (det_clear),
      .en       (det_en),
      .key      (core_key[KEY_W*g +: KEY_W]),
      .exhausted(exhausted[g])
    );
  end

  // Lowest index wins when several cores report in the same cycle.
  always_comb begin
    any_found = 1'b0;
    win_idx   = '0;
    win_key   = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (core_found[i] && !any_found) begin
        any_found = 1'b1;
        win_idx   = 8'(i);
        win_key   = core_key[KEY_W*i +: KEY_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      rst_cnt       <= '0;
      core_reset    <= 1'b0;
      core_start    <= 1'b0;
      busy          <= 1'b0;
      found         <= 1'b0;
      not_found     <= 1'b0;
      found_key     <= '0;
      found_core    <= '0;
      search_cycles <= '0;
    end else begin
      core_start <= 1'b0;
      case (state)
        IDLE, FOUND, EXHAUSTED: begin
          if (go) begin
            state         <= RESET_CORES;
            rst_cnt       <= CNT_W'(RST_CYCLES - 1);
            core_reset    <= 1'b1;
            busy          <= 1'b1;
            found         <= 1'b0;
            not_found     <= 1'b0;
            found_key     <= '0;
            found_core    <= '0;
            search_cycles <= '0;
          end
        end
        RESET_CORES: begin
          if (rst_cnt == '0) begin
            state      <= START;
            core_reset <= 1'b0;
            core_start <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt - CNT_W'(1);
          end
        end
        START: state <= SEARCH;
        SEARCH: begin
          if (search_cycles != 32'hFFFF_FFFF) search_cycles <= search_cycles + 32'd1;
          if (any_found) begin
            state      <= FOUND;
            found      <= 1'b1;
            found_key  <= win_key;
            found_core <= win_idx;
            core_reset <= 1'b1;
            busy       <= 1'b0;
          end else if (&exhausted) begin
            state     <= EXHAUSTED;
            not_found <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rc4_core_arbiter.sv
// Directed-random bench for rc4_core_arbiter with a spec-level outcome model.
module tb_rc4_core_arbiter;
  localparam int NC  = 4;
  localparam int RST = 4;

  logic            clk = 1'b0;
  logic            reset, go;
  logic [NC-1:0]   core_found;
  logic [24*NC-1:0] core_key;
  logic            core_reset, core_start, busy, found, not_found;
  logic [7:0]      total_cores, found_core;
  logic [23:0]     found_key;
  logic [31:0]     search_cycles;

  int checks = 0;
  int errors = 0;

  // model: 0 idle, 1 searching, 2 found, 3 exhausted
  int           mph = 0;
  int           m_sc = 0;
  int           m_core = 0;
  logic [23:0]  m_key = '0;
  bit   [NC-1:0] m_exh = '0;
  bit           m_pv = 0;
  logic [23:0]  m_prev [NC];

  rc4_core_arbiter #(.NUM_CORES(NC), .RST_CYCLES(RST)) dut (
    .clk(clk), .reset(reset), .go(go), .core_found(core_found), .core_key(core_key),
    .core_reset(core_reset), .core_start(core_start), .total_cores(total_cores),
    .busy(busy), .found(found), .not_found(not_found), .found_key(found_key),
    .found_core(found_core), .search_cycles(search_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".found"},     32'(found),      32'(mph == 2));
    chk({tag, ".not_found"}, 32'(not_found),  32'(mph == 3));
    chk({tag, ".busy"},      32'(busy),       32'(mph == 1));
    chk({tag, ".core_rst"},  32'(core_reset), 32'(mph == 2));
    chk({tag, ".cycles"},    search_cycles,   32'(m_sc));
    chk({tag, ".key"},       32'(found_key),  (mph == 2) ? 32'(m_key) : 32'd0);
    chk({tag, ".core"},      32'(found_core), (mph == 2) ? 32'(m_core) : 32'd0);
  endtask

  // One clock of stimulus; the model advances by the spec's outcome rules.
  task automatic step(input string tag, input logic [NC-1:0] mask,
                      input logic [24*NC-1:0] keys, input bit g);
    logic [NC-1:0] low;
    core_found = mask;
    core_key   = keys;
    go         = g;
    if (mph == 1) begin
      m_sc++;
      if (mask != 0) begin
        low    = mask & (~mask + 1'b1);
        m_core = $clog2(low);
        m_key  = keys[24*m_core +: 24];
        mph    = 2;
      end else if (&m_exh) begin
        mph = 3;
      end
      for (int i = 0; i < NC; i++) begin
        if (m_pv && keys[24*i +: 24] < m_prev[i]) m_exh[i] = 1'b1;
        m_prev[i] = keys[24*i +: 24];
      end
      m_pv = 1;
    end
    tick();
    go = 1'b0;
    chk_model(tag);
  endtask

  task automatic start_search(input string tag);
    go = 1'b1;
    tick();
    go = 1'b0;
    chk({tag, ".rst0"},   32'(core_reset), 32'd1);
    chk({tag, ".busy0"},  32'(busy), 32'd1);
    chk({tag, ".clrf"},   32'(found), 32'd0);
    chk({tag, ".clrk"},   32'(found_key), 32'd0);
    chk({tag, ".clrc"},   search_cycles, 32'd0);
    for (int i = 1; i < RST; i++) begin
      tick();
      chk({tag, ".rstN"},  32'(core_reset), 32'd1);
      chk({tag, ".nostart"}, 32'(core_start), 32'd0);
    end
    tick();
    chk({tag, ".start"},  32'(core_start), 32'd1);
    chk({tag, ".rstoff"}, 32'(core_reset), 32'd0);
    tick();
    chk({tag, ".start1"}, 32'(core_start), 32'd0);
    chk({tag, ".busy"},   32'(busy), 32'd1);
    mph = 1; m_sc = 0; m_pv = 0; m_exh = '0;
  endtask

  function automatic logic [24*NC-1:0] ramp(input int base);
    logic [24*NC-1:0] k;
    for (int i = 0; i < NC; i++) k[24*i +: 24] = 24'(base + 16*i);
    return k;
  endfunction

  initial begin
    int w [NC];
    int maxw, kc;
    logic [24*NC-1:0] kv;
    logic [NC-1:0] rm;

    reset = 1'b1; go = 1'b0; core_found = '0; core_key = '0;
    #12;
    chk("rst.total", 32'(total_cores), 32'(NC));
    chk_model("rst");
    @(negedge clk);
    reset = 1'b0;

    // idle up to cycle 10 with random core_found that must be ignored
    for (int c = 1; c < 10; c++) step("idle", NC'($urandom), 96'($urandom), 0);
    start_search("go1");

    kc = 100;
    for (int s = 0; s < 5; s++) begin
      step("srch1", '0, ramp(kc), (s == 2));
      kc += 3;
    end
    kv = ramp(kc);
    kv[24*2 +: 24] = 24'h0002A6;
    step("find2", 4'b0100, kv, 0);
    for (int s = 0; s < 3; s++) step("hold", NC'($urandom), 96'($urandom), 0);

    // restart from FOUND, then a two-winner cycle
    start_search("go2");
    for (int s = 0; s < 3; s++) begin step("srch2", '0, ramp(kc), 0); kc += 2; end
    kv = ramp(kc);
    kv[24*1 +: 24] = 24'($urandom);
    step("prio13", 4'b1010, kv, 0);

    // several randomised winner masks
    for (int r = 0; r < 4; r++) begin
      start_search("gor");
      for (int s = 0; s < int'($urandom_range(1, 6)); s++) begin
        step("srchr", '0, ramp(kc), ($urandom_range(0, 3) == 0)); kc += 2;
      end
      rm = NC'($urandom_range(1, (1 << NC) - 1));
      kv = ramp(kc);
      for (int i = 0; i < NC; i++) kv[24*i +: 24] = 24'($urandom) & 24'h3FFFFF;
      step("randwin", rm, kv, 0);
    end

    // full sweep: every core wraps at its own random step, no find
    for (int pass = 0; pass < 2; pass++) begin
      start_search("goex");
      maxw = 0;
      for (int i = 0; i < NC; i++) begin
        w[i] = $urandom_range(1, 6);
        if (w[i] > maxw) maxw = w[i];
      end
      for (int s = 0; s < 20 && mph == 1; s++) begin
        for (int i = 0; i < NC; i++)
          kv[24*i +: 24] = (s < w[i]) ? 24'(32'h3FFFFC + i - (w[i] - 1 - s)) : 24'(s - w[i]);
        rm = (pass == 1 && s == maxw + 1) ? NC'($urandom_range(1, (1 << NC) - 1)) : '0;
        step("sweep", rm, kv, 0);
      end
      if (pass == 0) chk("exh.nf", 32'(not_found), 32'd1);
      else           chk("race.found", 32'(found), 32'd1);
    end

    // async reset mid-search
    start_search("go3");
    for (int s = 0; s < 4; s++) begin step("srch3", '0, ramp(kc), 0); kc += 1; end
    #2 reset = 1'b1;
    #1;
    mph = 0; m_sc = 0;
    chk_model("areset");
    @(negedge clk);
    reset = 1'b0;
    for (int s = 0; s < 4; s++) step("postrst", NC'($urandom_range(1, (1 << NC) - 1)), ramp(kc), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
